// File: rtl/atpg_pkg.sv
// Shared types and constants for the two-pattern (init/launch) ATPG applier.
// The MISR constants are only used when ATPG_MISR_EN is defined.
package atpg_pkg;

  // Run sequencer states. Each pattern passes through INIT, LAUNCH and CAPTURE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LAUNCH,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam int              MISR_W    = 16;
  // Feedback taps for the polynomial x^16 + x^12 + x^5 + 1.
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  // Computes one MISR step: shift the state left, apply the feedback
  // polynomial when the bit shifted out is 1, then XOR in the new data word.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                  input logic [MISR_W-1:0] d);
    return {s[MISR_W-2:0], 1'b0} ^ (s[MISR_W-1] ? MISR_POLY : '0) ^ d;
  endfunction

endpackage

// File: rtl/atpg_pattern_ram.sv
// Pattern-pair storage: one word per slot holding {init, launch, exp, mask}.
// Writes are synchronous. Reads are combinational, so a slot written at a
// clock edge is visible to the reader during the next cycle.
module atpg_pattern_ram
  import atpg_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 1,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int W    = 2*IN_W + 2*OUT_W
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [IN_W-1:0]  i_init,
  input  logic [IN_W-1:0]  i_launch,
  input  logic [OUT_W-1:0] i_exp,
  input  logic [OUT_W-1:0] i_mask,
  input  logic [AW-1:0]    i_raddr,
  output logic [IN_W-1:0]  o_init,
  output logic [IN_W-1:0]  o_launch,
  output logic [OUT_W-1:0] o_exp,
  output logic [OUT_W-1:0] o_mask
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] w_rd;

  // Slot write. The contents are deliberately not reset, so patterns survive a reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= {i_init, i_launch, i_exp, i_mask};
  end

  assign w_rd     = r_mem[i_raddr];
  assign o_init   = w_rd[W-1 -: IN_W];
  assign o_launch = w_rd[2*OUT_W +: IN_W];
  assign o_exp    = w_rd[OUT_W +: OUT_W];
  assign o_mask   = w_rd[0 +: OUT_W];

endmodule

// File: rtl/atpg_pattern_applier.sv
// On-chip two-pattern transition-fault applier. Each stored pattern pair is
// applied as follows: the init vector is held for HOLD_CYC cycles, then the
// launch vector is held for CAPT_CYC cycles and through the capture cycle.
// The DUT response is then sampled and compared under the stored mask.
// Optional build macro ATPG_MISR_EN adds a 16-bit response signature output.
module atpg_pattern_applier
  import atpg_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 1,
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 2,
  parameter int CAPT_CYC = 1,
  parameter int CNT_W    = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_we,
  input  logic [AW-1:0]      ld_addr,
  input  logic [IN_W-1:0]    ld_init,
  input  logic [IN_W-1:0]    ld_launch,
  input  logic [OUT_W-1:0]   ld_exp,
  input  logic [OUT_W-1:0]   ld_mask,
  input  logic               start,
  input  logic [AW:0]        num_pat,
  output logic [IN_W-1:0]    dut_in,
  input  logic [OUT_W-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic               cap_valid,
  output logic [AW-1:0]      cap_idx,
  output logic [OUT_W-1:0]   cap_data,
  output logic               cap_fail,
`ifdef ATPG_MISR_EN
  output logic [MISR_W-1:0]  signature,
`endif
  output logic [CNT_W-1:0]   fail_cnt
);

  // state   | meaning
  // IDLE    | accept loads, wait for start
  // INIT    | drive init[idx] for HOLD_CYC cycles
  // LAUNCH  | drive launch[idx] for CAPT_CYC cycles
  // CAPTURE | hold launch[idx], sample dut_out at the closing edge
  // DONE    | one-cycle done pulse, then back to IDLE

  localparam int TMR_MAX = (HOLD_CYC > CAPT_CYC) ? HOLD_CYC : CAPT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] CAPT_LD = TMR_W'(CAPT_CYC - 1);

  state_e             r_state;
  logic [TMR_W-1:0]   r_tmr;
  logic [AW-1:0]      r_idx;
  logic [AW:0]        r_num;
  logic [IN_W-1:0]    r_dut_in;
  logic               r_busy;
  logic               r_done;
  logic               r_cap_valid;
  logic [AW-1:0]      r_cap_idx;
  logic [OUT_W-1:0]   r_cap_data;
  logic               r_cap_fail;
  logic [CNT_W-1:0]   r_fail_cnt;

  logic               w_we;
  logic [IN_W-1:0]    w_init;
  logic [IN_W-1:0]    w_launch;
  logic [OUT_W-1:0]   w_exp;
  logic [OUT_W-1:0]   w_mask;
  logic               w_miss;
  logic               w_last;

  // Storage is only writable in IDLE, so the patterns cannot change during a run.
  assign w_we   = ld_we && (r_state == ST_IDLE);
  assign w_miss = |((dut_out ^ w_exp) & w_mask);
  assign w_last = ({1'b0, r_idx} == (r_num - (AW+1)'(1)));

  atpg_pattern_ram #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (ld_addr),
    .i_init   (ld_init),
    .i_launch (ld_launch),
    .i_exp    (ld_exp),
    .i_mask   (ld_mask),
    .i_raddr  (r_idx),
    .o_init   (w_init),
    .o_launch (w_launch),
    .o_exp    (w_exp),
    .o_mask   (w_mask)
  );

`ifdef ATPG_MISR_EN
  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_cap_ext;
  assign w_cap_ext = MISR_W'(dut_out);
  assign signature = r_sig;

  // Signature register: cleared on an accepted start, stepped on each capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_sig <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_sig <= misr_step(r_sig, w_cap_ext);
    end
  end
`endif

  // Run sequencer. dut_in is registered, so it lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_idx       <= '0;
      r_num       <= '0;
      r_dut_in    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_idx   <= '0;
      r_cap_data  <= '0;
      r_cap_fail  <= 1'b0;
      r_fail_cnt  <= '0;
    end else begin
      r_done      <= 1'b0;
      r_cap_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_fail_cnt <= '0;
            if (num_pat != '0) begin
              r_num   <= num_pat;
              r_idx   <= '0;
              r_tmr   <= HOLD_LD;
              r_busy  <= 1'b1;
              r_state <= ST_INIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_INIT: begin
          r_dut_in <= w_init;
          if (r_tmr == '0) begin
            r_tmr   <= CAPT_LD;
            r_state <= ST_LAUNCH;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        ST_LAUNCH: begin
          r_dut_in <= w_launch;
          if (r_tmr == '0) r_state <= ST_CAPTURE;
          else             r_tmr   <= r_tmr - TMR_W'(1);
        end
        ST_CAPTURE: begin
          r_dut_in    <= w_launch;
          r_cap_valid <= 1'b1;
          r_cap_idx   <= r_idx;
          r_cap_data  <= dut_out;
          r_cap_fail  <= w_miss;
          if (w_miss && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + AW'(1);
            r_tmr   <= HOLD_LD;
            r_state <= ST_INIT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cap_valid = r_cap_valid;
  assign cap_idx   = r_cap_idx;
  assign cap_data  = r_cap_data;
  assign cap_fail  = r_cap_fail;
  assign fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_atpg_pattern_applier.sv
// Directed bench for atpg_pattern_applier driving the DUT model y=(a&b)|(e^f).
// Expected captures are queued when a run starts and checked as cap_valid fires.
// When ATPG_MISR_EN is defined, the signature is also checked against a model.
module tb_atpg_pattern_applier;

  localparam int IN_W = 4, OUT_W = 1, DEPTH = 4, HOLD_CYC = 2, CAPT_CYC = 1, CNT_W = 2;
  localparam int PER = HOLD_CYC + CAPT_CYC + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic ld_we;
  logic [1:0] ld_addr;
  logic [3:0] ld_init, ld_launch;
  logic [0:0] ld_exp, ld_mask;
  logic start;
  logic [2:0] num_pat;
  logic [3:0] dut_in;
  logic [0:0] dut_out;
  logic busy, done, cap_valid, cap_fail;
  logic [1:0] cap_idx;
  logic [0:0] cap_data;
  logic [CNT_W-1:0] fail_cnt;
`ifdef ATPG_MISR_EN
  logic [15:0] signature;
  logic [15:0] sig_m, sig_a;
`endif

  always #5 clk = ~clk;

  function automatic logic model(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] ^ v[0]);
  endfunction

  assign dut_out = model(dut_in);

  atpg_pattern_applier #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
    .HOLD_CYC(HOLD_CYC), .CAPT_CYC(CAPT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_init(ld_init), .ld_launch(ld_launch), .ld_exp(ld_exp), .ld_mask(ld_mask),
    .start(start), .num_pat(num_pat), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .cap_valid(cap_valid), .cap_idx(cap_idx),
    .cap_data(cap_data), .cap_fail(cap_fail),
`ifdef ATPG_MISR_EN
    .signature(signature),
`endif
    .fail_cnt(fail_cnt)
  );

  typedef struct packed {
    logic [1:0] idx;
    logic       data;
    logic       fail;
  } cap_t;

  cap_t sb[$];
  logic [3:0] m_init [4];
  logic [3:0] m_launch [4];
  logic       m_exp [4];
  logic       m_mask [4];
  logic [3:0] dlog [0:63];
  logic       blog [0:63];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_fc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int slot, input logic [3:0] ini, input logic [3:0] lau,
                      input logic ex, input logic mk);
    ld_we = 1'b1; ld_addr = 2'(slot); ld_init = ini; ld_launch = lau;
    ld_exp = ex; ld_mask = mk;
    m_init[slot] = ini; m_launch[slot] = lau; m_exp[slot] = ex; m_mask[slot] = mk;
  endtask

  // Queue the expected captures of an n-pattern run and model the count and signature.
  task automatic push_run(input int n);
    logic d, f;
    sb.delete();
    exp_fc = 0;
`ifdef ATPG_MISR_EN
    sig_m = '0;
`endif
    for (int i = 0; i < n; i++) begin
      d = model(m_launch[i]);
      f = (d ^ m_exp[i]) & m_mask[i];
      sb.push_back('{idx: 2'(i), data: d, fail: f});
      if (f && exp_fc < (1 << CNT_W) - 1) exp_fc++;
`ifdef ATPG_MISR_EN
      sig_m = {sig_m[14:0], 1'b0} ^ (sig_m[15] ? 16'h1021 : 16'h0000) ^ {15'd0, d};
`endif
    end
  endtask

  task automatic pulse_start(input int n);
    num_pat = 3'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; ld_we = 1'b0;
  endtask

  // Watch up to 'limit' cycles after start, checking captures and the done pulse.
  task automatic monitor(input int n, input int limit, input bit want_done, input string tag);
    cap_t e;
    int got;
    bit seen_done;
    got = 0; seen_done = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) @(negedge clk);
      dlog[k] = dut_in;
      blog[k] = busy;
      if (cap_valid) begin
        if (sb.size() == 0) begin
          chk({tag, "_cap_unexpected"}, 32'(cap_valid), 0);
        end else begin
          got++;
          e = sb.pop_front();
          chk({tag, "_cap_idx"}, 32'(cap_idx), 32'(e.idx));
          chk({tag, "_cap_data"}, 32'(cap_data), 32'(e.data));
          chk({tag, "_cap_fail"}, 32'(cap_fail), 32'(e.fail));
          chk({tag, "_cap_time"}, k, PER * got + 1);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, "_done_with_last_cap"}, 32'(cap_valid), 32'(n > 0));
        chk({tag, "_cap_count"}, got, n);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen_done), 32'(want_done));
  endtask

  initial begin
    rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_init = '0; ld_launch = '0;
    ld_exp = '0; ld_mask = '0; start = 1'b0; num_pat = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cap_valid", 32'(cap_valid), 0);
    chk("rst_dut_in", 32'(dut_in), 0);
    chk("rst_fail_cnt", 32'(fail_cnt), 0);
    chk("rst_cap_idx", 32'(cap_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pattern, with slot 0 written in the same cycle as start.
    load(0, 4'b0001, 4'b0110, 1'b1, 1'b1);
    push_run(1);
    pulse_start(1);
    monitor(1, 20, 1'b1, "t1");
    chk("t1_busy_c1", 32'(blog[1]), 1);
    chk("t1_init_c2", 32'(dlog[2]), 32'(4'b0001));
    chk("t1_init_c3", 32'(dlog[3]), 32'(4'b0001));
    chk("t1_launch_c4", 32'(dlog[4]), 32'(4'b0110));
    chk("t1_launch_c5", 32'(dlog[5]), 32'(4'b0110));
    chk("t1_fail_cnt", 32'(fail_cnt), 32'(exp_fc));
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_dut_in_hold", 32'(dut_in), 32'(4'b0110));

    // Four patterns; slot 1 responds 0 against an expected 1.
    load(0, 4'b0001, 4'b0110, 1'b1, 1'b1); @(negedge clk);
    load(1, 4'b0000, 4'b0111, 1'b1, 1'b1); @(negedge clk);
    load(2, 4'b0001, 4'b0000, 1'b0, 1'b1); @(negedge clk);
    load(3, 4'b0110, 4'b0001, 1'b1, 1'b1); @(negedge clk);
    ld_we = 1'b0;
    push_run(4);
    pulse_start(4);
    monitor(4, 40, 1'b1, "t2");
    chk("t2_fail_cnt", 32'(fail_cnt), 32'(exp_fc));
    chk("t2_fail_cnt_one", 32'(fail_cnt), 1);
`ifdef ATPG_MISR_EN
    chk("t2_signature", 32'(signature), 32'(sig_m));
`endif
    @(negedge clk);

    // Masking slot 1 makes it a don't-care.
    load(1, 4'b0000, 4'b0111, 1'b1, 1'b0); @(negedge clk);
    ld_we = 1'b0;
    push_run(4);
    pulse_start(4);
    monitor(4, 40, 1'b1, "t3");
    chk("t3_fail_cnt", 32'(fail_cnt), 0);
    @(negedge clk);

    // Zero patterns: done one cycle after start, busy never set.
    push_run(0);
    pulse_start(0);
    monitor(0, 6, 1'b1, "t4");
    chk("t4_busy", 32'(blog[1]), 0);
    @(negedge clk);

    // Reset during LAUNCH of pattern 2, then restart cleanly.
    load(1, 4'b0000, 4'b0111, 1'b1, 1'b1); @(negedge clk);
    ld_we = 1'b0;
    push_run(4);
    pulse_start(4);
    monitor(2, PER * 2 + 2, 1'b0, "t5a");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_dut_in", 32'(dut_in), 0);
    chk("t5_fail_cnt", 32'(fail_cnt), 0);
    chk("t5_done", 32'(done), 0);
    rst_n = 1'b1;
    sb.delete();
    monitor(0, 8, 1'b0, "t5b");
    push_run(4);
    pulse_start(4);
    monitor(4, 40, 1'b1, "t5c");
    chk("t5c_fail_cnt", 32'(fail_cnt), 32'(exp_fc));
    @(negedge clk);

    // Every pattern fails, so the 2-bit counter saturates at 3.
    load(0, 4'b0001, 4'b0110, 1'b0, 1'b1); @(negedge clk);
    load(1, 4'b0000, 4'b0111, 1'b1, 1'b1); @(negedge clk);
    load(2, 4'b0001, 4'b0000, 1'b1, 1'b1); @(negedge clk);
    load(3, 4'b0110, 4'b0001, 1'b0, 1'b1); @(negedge clk);
    ld_we = 1'b0;
    push_run(4);
    pulse_start(4);
    monitor(4, 40, 1'b1, "t6");
    chk("t6_fail_cnt_sat", 32'(fail_cnt), 3);
`ifdef ATPG_MISR_EN
    chk("t6_signature", 32'(signature), 32'(sig_m));
    sig_a = signature;
    chk("t6_sig_nonzero", 32'(sig_a != 16'h0), 1);
    @(negedge clk);
    push_run(4);
    pulse_start(4);
    monitor(4, 40, 1'b1, "t6b");
    chk("t6b_sig_repeat", 32'(signature), 32'(sig_a));
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
